// File: rtl/rr_grant_scheduler4.sv
// Round-robin scheduler for one 4-way shared resource.
// Grants are held until done, withdrawal or hold-time expiry.
module rr_grant_scheduler4 #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    last;
    logic [1:0]    win;
    logic [CW-1:0] cnt;
    logic          any_req;
    logic          own_done;
    logic          own_req;
    logic          expire;
    logic          rel;
    logic          take;

    assign any_req  = |req;
    assign own_done = done[gnt_idx];
    assign own_req  = req[gnt_idx];
    assign expire   = (cnt == CW'(MAX_HOLD - 1));
    assign rel      = own_done | ~own_req | expire;
    assign take     = (state != GRANT) && any_req;

    // Lower offsets overwrite higher ones, so last+1 has top priority.
    always_comb begin
        win = last;
        for (int k = 3; k >= 1; k--) begin
            if (req[last + 2'(k)]) begin
                win = last + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (rel) state_nxt = GAP;
            GAP:     state_nxt = any_req ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 2'd3;
            gnt_idx <= 2'd0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            // Timeout only when expiry is the sole release cause.
            timeout <= (state == GRANT) && expire && !own_done && own_req;
            if (take) begin
                gnt_idx <= win;
                last    <= win;
                cnt     <= '0;
            end else if (state == GRANT && !rel) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        gnt_valid = (state == GRANT);
        gnt       = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
    end

endmodule

// File: tb/tb_rr_grant_scheduler4.sv
// Scoreboard bench for rr_grant_scheduler4: expected output tuples
// are queued as each cycle's stimulus is driven.
module tb_rr_grant_scheduler4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb [$];

    rr_grant_scheduler4 #(.MAX_HOLD(8), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Row: {rst, req, done, gnt, gnt_idx, gnt_valid, timeout}
    function automatic logic [16:0] row(
        input logic rs, input logic [3:0] r, input logic [3:0] d,
        input logic [3:0] g, input logic [1:0] i,
        input logic v, input logic to);
        return {rs, r, d, g, i, v, to};
    endfunction

    task automatic drive(input logic [16:0] t);
        @(negedge clk);
        rst  = t[16];
        req  = t[15:12];
        done = t[11:8];
        sb.push_back(t[7:0]);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {gnt, gnt_idx, gnt_valid, timeout};
    endfunction

    task automatic test_reset();
        logic [16:0] t [$];
        logic [7:0]  e;
        t.push_back(row(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0));
        t.push_back(row(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b1111, 4'b0001, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_single();
        logic [16:0] t [$];
        logic [7:0]  e;
        t.push_back(row(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(0, 4'b0100, 4'b0100, 4'b0000, 2, 0, 0));
        t.push_back(row(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(0, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL single[%0d]: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_rotation();
        logic [16:0] t [$];
        logic [7:0]  e;
        t.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b1111, 4'b0001, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0));
        t.push_back(row(0, 4'b1111, 4'b0010, 4'b0000, 1, 0, 0));
        t.push_back(row(0, 4'b1111, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(0, 4'b1111, 4'b0100, 4'b0000, 2, 0, 0));
        t.push_back(row(0, 4'b1111, 4'b0000, 4'b1000, 3, 1, 0));
        t.push_back(row(0, 4'b1111, 4'b1000, 4'b0000, 3, 0, 0));
        t.push_back(row(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL rotation[%0d]: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [16:0] t [$];
        logic [7:0]  e;
        t.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        for (int c = 0; c < 8; c++) begin
            t.push_back(row(0, 4'b0011, 4'b0000, 4'b0001, 0, 1, 0));
        end
        t.push_back(row(0, 4'b0011, 4'b0000, 4'b0000, 0, 0, 1));
        t.push_back(row(0, 4'b0011, 4'b0000, 4'b0010, 1, 1, 0));
        t.push_back(row(0, 4'b0011, 4'b0010, 4'b0000, 1, 0, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [16:0] t [$];
        logic [7:0]  e;
        t.push_back(row(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b0100, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b1110, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0101, 4'b0001, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b0101, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(0, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL simul[%0d]: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] t [$];
        logic [7:0]  e;
        t.push_back(row(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
        t.push_back(row(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0));
        t.push_back(row(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL midrst[%0d]: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_withdraw();
        logic [16:0] t [$];
        logic [7:0]  e;
        t.push_back(row(0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        t.push_back(row(0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        t.push_back(row(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 0));
        t.push_back(row(0, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0));
        t.push_back(row(0, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            e = sb.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL withdraw[%0d]: got %b want %b", k, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_simultaneous();
        test_mid_reset();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
